enc_stream_ctrl: RTL and testbench
==================================

Name: enc_stream_ctrl

Overview:
Sequencing controller for the byte-wise key-additive encryptor datapath. Loads a SEC_LEN-byte secret, then streams a MSG_LEN-byte plaintext through the add-key stage, cycling the key index modulo SEC_LEN, with valid/ready handshakes on every interface. It sits between the host-side message source and the ciphertext sink. It replaces static array preloading of text_in and secret with a clocked, back-pressurable transfer.

Parameters:
MSG_LEN, 20, number of plaintext bytes per message (>=1)
SEC_LEN, 3, number of key bytes (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a new key-load + message sequence (sampled in IDLE only)
key_valid  in  1  key byte valid
key_data  in  8  key byte
key_ready  out  1  controller accepts key byte
in_valid  in  1  plaintext byte valid
in_data  in  8  plaintext byte
in_ready  out  1  controller accepts plaintext byte
out_valid  out  1  ciphertext byte valid
out_data  out  8  ciphertext byte
out_ready  in  1  sink accepts ciphertext byte
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the last ciphertext byte is accepted
byte_count  out  $clog2(MSG_LEN+1)  ciphertext bytes accepted so far in the current message

Behaviour:
- Reset, asynchronous: state=IDLE. key_ready, in_ready, out_valid, busy and done are 0. out_data=0, byte_count=0, key index=0, key store cleared to 0.
- States: IDLE -> LOAD_KEY -> RUN -> DONE -> IDLE.
- IDLE: start=1 moves to LOAD_KEY, clears byte_count, key index and input counter. start in any other state is ignored.
- LOAD_KEY: key_ready=1. Each cycle with key_valid&key_ready writes key_data to key[kcnt] and increments kcnt. After key byte SEC_LEN-1 is accepted, go to RUN with key index=0.
- RUN: in_ready = (!out_valid || out_ready) && (inputs accepted < MSG_LEN).
  - On an in_valid&in_ready transfer, out_data <= (in_data + key[kidx]) mod 256, truncated to 8 bits, and out_valid <= 1.
  - Then kidx <= (kidx==SEC_LEN-1) ? 0 : kidx+1.
  - Latency: 1 cycle from input acceptance to out_valid.
  - Full throughput of 1 byte/cycle while out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, out_data is stable and in_ready=0.
- Simultaneous events: out_ready accepting the current byte and a new input transfer in the same cycle loads the new byte, keeps out_valid=1, and increments byte_count.
- byte_count increments on every out_valid&out_ready.
- When byte_count reaches MSG_LEN, go to DONE. out_valid is 0 at that point.
- DONE: done=1 for exactly one cycle, then IDLE. byte_count holds its final value until the next start.
- Inputs are ignored outside their states: key_valid outside LOAD_KEY, and in_valid outside RUN or after MSG_LEN inputs.
- Reset asserted mid-operation aborts immediately to the reset values. Any partial ciphertext is discarded.
- SEC_LEN=1: kidx stays at 0. MSG_LEN=1: a single transfer, then DONE.

Optional Feature:
ENC_CHAIN_EN
- Defined: chaining mode. out_data = (in_data + key[kidx] + prev) mod 256.
  - prev is the previous ciphertext byte of the current message, 0 for the first byte.
  - prev is cleared on start and on reset.
  - Breaks the repetition of identical plaintext/key pairs.
- Undefined: plain additive mode as above. No prev register is synthesized.

Test Plan:
- Basic, no macro: key 0x4B,0x45,0x59 ("KEY"), MSG_LEN=4, plaintext 0x41,0x41,0x42,0x42 ("AABB"), out_ready=1 -> out 0x8C,0x86,0x9B,0x8D; done pulses once; byte_count=4; busy falls the cycle after done.
- Key wrap: MSG_LEN=20 with the repetitive text AABBCCDDEEAABBCCDDEE and key KEY -> byte i uses key[i mod 3]; byte 3 = 0x42+0x4B = 0x8D; byte 19 = 0x45+0x45 = 0x8A.
- Backpressure: hold out_ready=0 for 5 cycles after the first output -> in_ready=0 and out_data stable at 0x8C throughout; no bytes lost or duplicated after release.
- Reset mid-RUN: assert rst after 2 bytes -> all outputs return to reset values. A new start and key reload produce the correct stream from byte 0.
- Ignored inputs: start pulsed during RUN and key_valid during RUN -> no state change, key unchanged.
- With ENC_CHAIN_EN: key KEY, plaintext AAB -> out 0x8C,0x12,0xAD.

Source files
------------

// File: rtl/enc_stream_ctrl.sv
// ---------------------------------------------------------------------------
// enc_stream_ctrl
//
// Sequencing controller for the byte-wise key-additive encryptor. A sequence
// begins with start in IDLE. The controller then accepts SEC_LEN key bytes
// over the key handshake, followed by MSG_LEN plaintext bytes over the input
// handshake. Each plaintext byte leaves as a ciphertext byte:
//   ct = (pt + key[kidx]) mod 256
// The key index cycles modulo SEC_LEN. The add-key stage is a single
// register, so a byte reaches the output one cycle after acceptance. The
// stage is skid-free: new input is taken only when the output register is
// empty or is being drained in the same cycle.
//
// Optional feature (macro ENC_CHAIN_EN):
//   When defined, chaining mode adds the previous ciphertext byte of the
//   current message:
//     ct = (pt + key[kidx] + prev) mod 256
//   prev is 0 for the first byte. When undefined, no prev register exists.
//
// Parameters:
//   MSG_LEN  plaintext bytes per message (>=1)
//   SEC_LEN  key bytes (>=1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   start       begin key-load + message sequence (IDLE only)
//   key_valid   key byte valid
//   key_data    key byte
//   key_ready   controller accepts key byte (LOAD_KEY)
//   in_valid    plaintext byte valid
//   in_data     plaintext byte
//   in_ready    controller accepts plaintext byte (RUN)
//   out_valid   ciphertext byte valid
//   out_data    ciphertext byte
//   out_ready   sink accepts ciphertext byte
//   busy        high in every state except IDLE
//   done        one-cycle pulse after the last ciphertext byte is accepted
//   byte_count  ciphertext bytes accepted in the current message
// ---------------------------------------------------------------------------
module enc_stream_ctrl #(
  parameter int MSG_LEN = 20,
  parameter int SEC_LEN = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           key_valid,
  input  logic [7:0]                     key_data,
  output logic                           key_ready,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [7:0]                     out_data,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(MSG_LEN+1)-1:0]   byte_count
);

  localparam int CW = $clog2(MSG_LEN + 1);
  localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;

  localparam logic [CW-1:0] MSG_END  = CW'(MSG_LEN);
  localparam logic [CW-1:0] MSG_LAST = CW'(MSG_LEN - 1);
  localparam logic [KW-1:0] KEY_LAST = KW'(SEC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_KEY = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [7:0]      key_mem [SEC_LEN];
  logic [KW-1:0]   kcnt;
  logic [KW-1:0]   kidx;
  logic [CW-1:0]   icnt;
  logic [CW-1:0]   ocnt;

  logic            vld_p1;
  logic [7:0]      ct_p1;
  logic [7:0]      ct_p0;

  logic            key_fire;
  logic            in_fire;
  logic            out_fire;
  logic            seq_start;

`ifdef ENC_CHAIN_EN
  logic [7:0]      prev_p1;
`endif

  // Byte addition with natural mod-256 wrap.
  function automatic logic [7:0] add_mod256(input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0];
  endfunction

  // Key index advance with wrap at SEC_LEN.
  function automatic logic [KW-1:0] next_kidx(input logic [KW-1:0] idx);
    return (idx == KEY_LAST) ? '0 : idx + 1'b1;
  endfunction

  assign out_valid  = vld_p1;
  assign out_data   = ct_p1;
  assign byte_count = ocnt;

  assign seq_start = (state == IDLE) && start;
  assign key_fire  = key_valid && key_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = vld_p1 && out_ready;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD_KEY;
      end
      LOAD_KEY: begin
        key_ready = 1'b1;
        if (key_valid && (kcnt == KEY_LAST)) state_nxt = RUN;
      end
      RUN: begin
        // Accept only while the output register can take the byte, and
        // never beyond the message length.
        in_ready = (!vld_p1 || out_ready) && (icnt < MSG_END);
        if (out_fire && (ocnt == MSG_LAST)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequence counters and output-valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kcnt   <= '0;
      kidx   <= '0;
      icnt   <= '0;
      ocnt   <= '0;
      vld_p1 <= 1'b0;
    end else if (seq_start) begin
      kcnt   <= '0;
      kidx   <= '0;
      icnt   <= '0;
      ocnt   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (key_fire) begin
        kcnt <= next_kidx(kcnt);
        if (kcnt == KEY_LAST) kidx <= '0;
      end
      if (in_fire) begin
        icnt <= icnt + 1'b1;
        kidx <= next_kidx(kidx);
      end
      // A simultaneous drain and reload keeps the register full.
      if (in_fire) begin
        vld_p1 <= 1'b1;
      end else if (out_fire) begin
        vld_p1 <= 1'b0;
      end
      if (out_fire) ocnt <= ocnt + 1'b1;
    end
  end

  // Stage p0: key addition on the accepted byte
  always_comb begin
    ct_p0 = add_mod256(in_data, key_mem[kidx]);
`ifdef ENC_CHAIN_EN
    ct_p0 = add_mod256(ct_p0, prev_p1);
`endif
  end

  // Key store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SEC_LEN; i++) key_mem[i] <= 8'h00;
    end else if (key_fire) begin
      key_mem[kcnt] <= key_data;
    end
  end

  // Stage p1: ciphertext register, held while the sink stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct_p1 <= 8'h00;
    end else if (in_fire) begin
      ct_p1 <= ct_p0;
    end
  end

`ifdef ENC_CHAIN_EN
  // Chaining feedback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_p1 <= 8'h00;
    end else if (seq_start) begin
      prev_p1 <= 8'h00;
    end else if (in_fire) begin
      prev_p1 <= ct_p0;
    end
  end
`endif

endmodule

// File: tb/tb_enc_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_enc_stream_ctrl
//
// Directed bench for enc_stream_ctrl with MSG_LEN=20 and SEC_LEN=3. The key
// is "KEY" and the message is "AABBCCDDEEAABBCCDDEE". The vector table holds
// each plaintext byte with its hand-computed plain-additive ciphertext. With
// ENC_CHAIN_EN, the expected stream is chained from the table. Sequences
// cover the basic and wrapping stream, ignored start/key during RUN, sink
// backpressure, and reset during RUN.
// ---------------------------------------------------------------------------
module tb_enc_stream_ctrl;

  localparam int MSG_LEN = 20;
  localparam int SEC_LEN = 3;
  localparam int CW      = $clog2(MSG_LEN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          key_valid;
  logic [7:0]    key_data;
  logic          key_ready;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] byte_count;

  typedef struct {
    logic [7:0] pt;
    logic [7:0] ct;
  } vec_t;

  vec_t       vecs [MSG_LEN];
  logic [7:0] exp_ct [MSG_LEN];
  logic [7:0] key_bytes [SEC_LEN];

  int n_cmp = 0;
  int n_err = 0;

  enc_stream_ctrl #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .key_ready  (key_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_key_ready"},  key_ready,  0);
    check({tag, "_in_ready"},   in_ready,   0);
    check({tag, "_out_valid"},  out_valid,  0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_out_data"},   out_data,   0);
    check({tag, "_byte_count"}, byte_count, 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_busy", busy, 1);
    check("start_byte_count", byte_count, 0);
  endtask

  task automatic load_key();
    for (int i = 0; i < SEC_LEN; i++) begin
      @(negedge clk);
      key_valid = 1'b1;
      key_data  = key_bytes[i];
      #1 check("load_key_ready", key_ready, 1);
      @(posedge clk);
    end
    #1 key_valid = 1'b0;
    key_data = 8'h00;
  endtask

  // Streams one message. stall_at/stall_len hold out_ready low for stall_len
  // cycles while output byte stall_at is presented. abort_after>0 returns
  // once that many outputs have been checked. poke pulses start and key_valid
  // mid-message; those must be ignored.
  task automatic run_msg(input int stall_at, input int stall_len,
                         input int abort_after, input bit poke);
    int icnt    = 0;
    int ocnt    = 0;
    int stalled = 0;
    int cyc     = 0;
    bit fin     = 1'b0;
    bit poked   = 1'b0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start     = 1'b0;
      key_valid = 1'b0;
      key_data  = 8'h00;
      if (done) begin
        check("done_byte_count", byte_count, MSG_LEN);
        check("done_out_valid", out_valid, 0);
        check("done_outputs_seen", ocnt, MSG_LEN);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("after_done_pulse", done, 0);
        check("after_done_busy", busy, 0);
        check("after_done_byte_count", byte_count, MSG_LEN);
        fin = 1'b1;
      end else begin
        out_ready = 1'b1;
        if (out_valid && ocnt == stall_at && stalled < stall_len)
          out_ready = 1'b0;
        in_valid = (icnt < MSG_LEN);
        in_data  = (icnt < MSG_LEN) ? vecs[icnt].pt : 8'h00;
        if (poke && !poked && icnt == 5) begin
          start     = 1'b1;
          key_valid = 1'b1;
          key_data  = 8'hFF;
        end
        #1;
        if (poke && !poked && icnt == 5) begin
          poked = 1'b1;
          check("poke_key_ready", key_ready, 0);
          check("poke_busy", busy, 1);
        end
        if (out_valid && !out_ready) begin
          stalled++;
          check("stall_in_ready", in_ready, 0);
          check("stall_out_data", out_data, exp_ct[ocnt]);
        end
        if (out_valid && out_ready) begin
          if (ocnt < MSG_LEN) check($sformatf("out_byte_%0d", ocnt), out_data, exp_ct[ocnt]);
          else check("extra_output", 1, 0);
          ocnt++;
        end
        if (in_valid && in_ready) icnt++;
        if (abort_after > 0 && ocnt == abort_after) fin = 1'b1;
      end
    end
    if (!fin) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_timeout: got %0d outputs, required done within budget", ocnt);
    end
  endtask

  initial begin
    // "AABBCCDDEEAABBCCDDEE" with key "KEY", plain additive ciphertext
    vecs[0]  = '{8'h41, 8'h8C}; vecs[1]  = '{8'h41, 8'h86};
    vecs[2]  = '{8'h42, 8'h9B}; vecs[3]  = '{8'h42, 8'h8D};
    vecs[4]  = '{8'h43, 8'h88}; vecs[5]  = '{8'h43, 8'h9C};
    vecs[6]  = '{8'h44, 8'h8F}; vecs[7]  = '{8'h44, 8'h89};
    vecs[8]  = '{8'h45, 8'h9E}; vecs[9]  = '{8'h45, 8'h90};
    vecs[10] = '{8'h41, 8'h86}; vecs[11] = '{8'h41, 8'h9A};
    vecs[12] = '{8'h42, 8'h8D}; vecs[13] = '{8'h42, 8'h87};
    vecs[14] = '{8'h43, 8'h9C}; vecs[15] = '{8'h43, 8'h8E};
    vecs[16] = '{8'h44, 8'h89}; vecs[17] = '{8'h44, 8'h9D};
    vecs[18] = '{8'h45, 8'h90}; vecs[19] = '{8'h45, 8'h8A};
    key_bytes[0] = 8'h4B;
    key_bytes[1] = 8'h45;
    key_bytes[2] = 8'h59;
    for (int i = 0; i < MSG_LEN; i++) begin
`ifdef ENC_CHAIN_EN
      // Chained: first three become 0x8C, 0x12, 0xAD
      exp_ct[i] = vecs[i].ct + ((i > 0) ? exp_ct[i-1] : 8'h00);
`else
      exp_ct[i] = vecs[i].ct;
`endif
    end

    rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_data = 8'h00;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    #7;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic stream with key wrap; start/key_valid poked during RUN
    do_start();
    load_key();
    run_msg(-1, 0, 0, 1'b1);

    // Backpressure on the first output byte
    do_start();
    load_key();
    run_msg(0, 5, 0, 1'b0);

    // Reset during RUN, then a full fresh sequence
    do_start();
    load_key();
    run_msg(-1, 0, 2, 1'b0);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1 check_reset_values("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    do_start();
    load_key();
    run_msg(-1, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
